exec_ctl: RTL and testbench

Parametrised execute-stage controller for SimpleCore, the successor to the fixed decode-to-execute control register. It latches a decoded control bundle into the execute stage and evaluates a 4-bit condition field against the N/Z/C/V flags. It also interlocks on a register scoreboard for multi-cycle (long-latency) operations, issues the branch flush, runs a refill squash window and halts on an exit instruction.

---
 rtl/exec_ctl.sv | 167 ++++++++++++++++
 tb/tb_exec_ctl.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctl.sv
// Execute-stage controller: latches the decoded bundle, evaluates the condition code,
// interlocks on a busy scoreboard for long-latency results, and drives flush, refill squash and halt.
module exec_ctl #(
    parameter int IDXW   = 4,
    parameter int CTLW   = 24,
    parameter int MULLAT = 2,
    parameter int REFILL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dValid,
    output logic            dReady,
    input  logic [3:0]      dCond,
    input  logic [IDXW-1:0] dSrcA,
    input  logic [IDXW-1:0] dSrcB,
    input  logic            dSrcAEn,
    input  logic            dSrcBEn,
    input  logic [IDXW-1:0] dWbIdx,
    input  logic            dWbEn,
    input  logic            dSrWbEn,
    input  logic            dLong,
    input  logic            dBranch,
    input  logic            dExit,
    input  logic [CTLW-1:0] dCtl,
    input  logic [3:0]      flags,
    output logic            eValid,
    output logic [CTLW-1:0] eCtl,
    output logic [IDXW-1:0] wbIdx,
    output logic            wbEn,
    output logic            srWbEn,
    output logic            flush,
    output logic            lwbEn,
    output logic [IDXW-1:0] lwbIdx,
    output logic            halted
);

    localparam int NREG = 2 ** IDXW;
    localparam int RCW  = $clog2(REFILL + 2);

    typedef struct packed {
        logic [3:0]      cond;
        logic [IDXW-1:0] wb_idx;
        logic            wb_en;
        logic            sr_wb_en;
        logic            lng;
        logic            branch;
        logic            ext;
        logic [CTLW-1:0] ctl;
    } ex_t;

    ex_t             ex_q, ex_d;
    logic            e_valid_q, e_valid_d;
    logic [RCW-1:0]  refill_q, refill_d;
    logic            halted_q, halted_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [MULLAT-1:0] dl_vld_q, dl_vld_d;
    logic [IDXW-1:0] dl_idx_q [MULLAT];
    logic [IDXW-1:0] dl_idx_d [MULLAT];

    logic n_f, z_f, c_f, v_f;
    logic cond_pass, commit, long_commit, hazard, load;

    assign {n_f, z_f, c_f, v_f} = flags;

    assign eValid = e_valid_q;
    assign eCtl   = ex_q.ctl;
    assign wbIdx  = ex_q.wb_idx;
    assign halted = halted_q;
    assign lwbEn  = dl_vld_q[MULLAT-1];
    assign lwbIdx = dl_idx_q[MULLAT-1];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cond_pass = 1'b0;
        case (ex_q.cond)
            4'd0:    cond_pass = z_f;
            4'd1:    cond_pass = ~z_f;
            4'd2:    cond_pass = c_f;
            4'd3:    cond_pass = ~c_f;
            4'd4:    cond_pass = n_f;
            4'd5:    cond_pass = ~n_f;
            4'd6:    cond_pass = v_f;
            4'd7:    cond_pass = ~v_f;
            4'd8:    cond_pass = c_f & ~z_f;
            4'd9:    cond_pass = ~c_f | z_f;
            4'd10:   cond_pass = (n_f == v_f);
            4'd11:   cond_pass = (n_f != v_f);
            4'd12:   cond_pass = ~z_f & (n_f == v_f);
            4'd13:   cond_pass = z_f | (n_f != v_f);
            4'd14:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase

        commit      = e_valid_q & cond_pass & (refill_q == '0);
        wbEn        = commit & ex_q.wb_en & ~ex_q.lng;
        srWbEn      = commit & ex_q.sr_wb_en;
        flush       = commit & ex_q.branch;
        long_commit = commit & ex_q.lng & ex_q.wb_en;

        // busy_q still holds entries retiring this cycle, so a reader issues only after lwbEn.
        hazard = dValid & ((dSrcAEn & busy_q[dSrcA]) |
                           (dSrcBEn & busy_q[dSrcB]) |
                           (dWbEn   & busy_q[dWbIdx]));
        dReady = ~halted_q & (~hazard | flush);
        load   = dValid & dReady & ~flush;

        e_valid_d = load;
        ex_d      = ex_q;
        if (load) begin
            ex_d.cond     = dCond;
            ex_d.wb_idx   = dWbIdx;
            ex_d.wb_en    = dWbEn;
            ex_d.sr_wb_en = dSrWbEn;
            ex_d.lng      = dLong;
            ex_d.branch   = dBranch;
            ex_d.ext      = dExit;
            ex_d.ctl      = dCtl;
        end

        refill_d = refill_q;
        if (flush)
            refill_d = RCW'(REFILL);
        else if (refill_q != '0)
            refill_d = refill_q - RCW'(1);

        halted_d = halted_q | (commit & ex_q.ext);

        // Set after clear so a new long op wins over a retiring one in the same cycle.
        busy_d = busy_q;
        if (lwbEn)
            busy_d[lwbIdx] = 1'b0;
        if (long_commit)
            busy_d[ex_q.wb_idx] = 1'b1;

        dl_vld_d[0] = long_commit;
        dl_idx_d[0] = ex_q.wb_idx;
        for (int i = 1; i < MULLAT; i++) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_idx_d[i] = dl_idx_q[i-1];
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q      <= '0;
            e_valid_q <= 1'b0;
            refill_q  <= '0;
            halted_q  <= 1'b0;
            busy_q    <= '0;
            dl_vld_q  <= '0;
            // NOTE: the delay-line indices are flops, not RAM, and are reset so lwbIdx reads 0 out of reset.
            for (int i = 0; i < MULLAT; i++)
                dl_idx_q[i] <= '0;
        end else begin
            ex_q      <= ex_d;
            e_valid_q <= e_valid_d;
            refill_q  <= refill_d;
            halted_q  <= halted_d;
            busy_q    <= busy_d;
            dl_vld_q  <= dl_vld_d;
            for (int i = 0; i < MULLAT; i++)
                dl_idx_q[i] <= dl_idx_d[i];
        end
    end

endmodule

// File: tb/tb_exec_ctl.sv
// Self-checking bench for exec_ctl: directed cycle checks plus a scoreboard of
// expected short and long writebacks popped as the DUT commits them.
module tb_exec_ctl;
    localparam int IDXW = 4, CTLW = 24, MULLAT = 2, REFILL = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            dValid, dReady;
    logic [3:0]      dCond;
    logic [IDXW-1:0] dSrcA, dSrcB, dWbIdx;
    logic            dSrcAEn, dSrcBEn, dWbEn, dSrWbEn, dLong, dBranch, dExit;
    logic [CTLW-1:0] dCtl;
    logic [3:0]      flags;
    logic            eValid, wbEn, srWbEn, flush, lwbEn, halted;
    logic [CTLW-1:0] eCtl;
    logic [IDXW-1:0] wbIdx, lwbIdx;

    exec_ctl #(.IDXW(IDXW), .CTLW(CTLW), .MULLAT(MULLAT), .REFILL(REFILL)) dut (
        .clk(clk), .reset(reset), .dValid(dValid), .dReady(dReady), .dCond(dCond),
        .dSrcA(dSrcA), .dSrcB(dSrcB), .dSrcAEn(dSrcAEn), .dSrcBEn(dSrcBEn),
        .dWbIdx(dWbIdx), .dWbEn(dWbEn), .dSrWbEn(dSrWbEn), .dLong(dLong),
        .dBranch(dBranch), .dExit(dExit), .dCtl(dCtl), .flags(flags),
        .eValid(eValid), .eCtl(eCtl), .wbIdx(wbIdx), .wbEn(wbEn), .srWbEn(srWbEn),
        .flush(flush), .lwbEn(lwbEn), .lwbIdx(lwbIdx), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  cond;
        logic [3:0]  a;
        logic        aen;
        logic [3:0]  b;
        logic        ben;
        logic [3:0]  wb;
        logic        wben;
        logic        srwb;
        logic        lng;
        logic        br;
        logic        ex;
        logic [23:0] ctl;
    } op_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [23:0] ctl;
    } sexp_t;

    sexp_t      sq[$];
    logic [3:0] lq[$];
    sexp_t      se;
    logic [3:0] le;
    op_t        o1, o2, o3;
    int         n_cmp = 0, n_err = 0;
    int         ctl_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [23:0] nxt();
        ctl_n++;
        return 24'(ctl_n * 37 + 5);
    endfunction

    function automatic op_t sop(input logic [3:0] wb);
        op_t o;
        o      = '0;
        o.cond = 4'd14;
        o.wb   = wb;
        o.wben = 1'b1;
        o.ctl  = nxt();
        return o;
    endfunction

    function automatic op_t lop(input logic [3:0] wb);
        op_t o;
        o     = sop(wb);
        o.lng = 1'b1;
        return o;
    endfunction

    task automatic drive(input op_t o);
        dValid  = 1'b1;
        dCond   = o.cond;
        dSrcA   = o.a;
        dSrcAEn = o.aen;
        dSrcB   = o.b;
        dSrcBEn = o.ben;
        dWbIdx  = o.wb;
        dWbEn   = o.wben;
        dSrWbEn = o.srwb;
        dLong   = o.lng;
        dBranch = o.br;
        dExit   = o.ex;
        dCtl    = o.ctl;
    endtask

    task automatic idle();
        drive('0);
        dValid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    // Scoreboard: every committed writeback must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (wbEn) begin
                check("sb_short_pending", sq.size() != 0, 1);
                if (sq.size() != 0) begin
                    se = sq.pop_front();
                    check("sb_wbidx", wbIdx, se.idx);
                    check("sb_ectl", eCtl, se.ctl);
                end
            end
            if (lwbEn) begin
                check("sb_long_pending", lq.size() != 0, 1);
                if (lq.size() != 0) begin
                    le = lq.pop_front();
                    check("sb_lwbidx", lwbIdx, le);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        flags = 4'h0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        look();
        check("rst_evalid", eValid, 0);
        check("rst_ectl", eCtl, 0);
        check("rst_wbidx", wbIdx, 0);
        check("rst_wben", wbEn, 0);
        check("rst_srwben", srWbEn, 0);
        check("rst_flush", flush, 0);
        check("rst_lwben", lwbEn, 0);
        check("rst_lwbidx", lwbIdx, 0);
        check("rst_halted", halted, 0);
        check("rst_dready", dReady, 1);
        step();
        reset = 1'b0;
        step();

        // Condition matrix
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                flags = 4'(f);
                o1 = sop(4'd1);
                drive(o1);
                sq.push_back({o1.wb, o1.ctl});
                look();
                check("mx_rdy", dReady, 1);
                step();
                o2 = sop(4'd2);
                o2.cond = 4'(c);
                drive(o2);
                if (cond_ok(4'(c), 4'(f)))
                    sq.push_back({o2.wb, o2.ctl});
                look();
                check("mx_al_wb", wbEn, 1);
                step();
                idle();
                look();
                check($sformatf("mx_c%0d_f%0h", c, f), wbEn, cond_ok(4'(c), 4'(f)));
                step();
            end
        end
        flags = 4'h0;

        // Long-op RAW: long r3 commits at rel cycle 5, reader of r3 presented from cycle 6
        o1 = lop(4'd3);
        drive(o1);
        lq.push_back(4'd3);
        look();
        check("raw_c4_rdy", dReady, 1);
        step();
        idle();
        look();
        check("raw_c5_evalid", eValid, 1);
        check("raw_c5_noshort", wbEn, 0);
        step();
        o2 = sop(4'd4);
        o2.a = 4'd3;
        o2.aen = 1'b1;
        drive(o2);
        look();
        check("raw_c6_rdy", dReady, 0);
        check("raw_c6_lwb", lwbEn, 0);
        step();
        look();
        check("raw_c7_rdy", dReady, 0);
        check("raw_c7_lwb", lwbEn, 1);
        check("raw_c7_lwbidx", lwbIdx, 3);
        step();
        look();
        check("raw_c8_rdy", dReady, 1);
        sq.push_back({o2.wb, o2.ctl});
        step();
        idle();
        look();
        check("raw_c9_evalid", eValid, 1);
        check("raw_c9_wb", wbEn, 1);
        check("raw_c9_wbidx", wbIdx, 4);
        step();

        // WAW then in-order independent op
        o1 = lop(4'd5);
        drive(o1);
        lq.push_back(4'd5);
        look();
        step();
        idle();
        look();
        step();
        o2 = sop(4'd5);
        drive(o2);
        look();
        check("waw_c2_rdy", dReady, 0);
        step();
        look();
        check("waw_c3_rdy", dReady, 0);
        check("waw_c3_lwb", lwbEn, 1);
        check("waw_c3_lwbidx", lwbIdx, 5);
        step();
        look();
        check("waw_c4_rdy", dReady, 1);
        sq.push_back({o2.wb, o2.ctl});
        step();
        o3 = sop(4'd6);
        drive(o3);
        look();
        check("waw_c5_rdy", dReady, 1);
        check("waw_c5_wb", wbEn, 1);
        sq.push_back({o3.wb, o3.ctl});
        step();
        idle();
        look();
        check("waw_c6_wbidx", wbIdx, 6);
        step();

        // Independent op first: no stall
        o1 = lop(4'd5);
        drive(o1);
        lq.push_back(4'd5);
        look();
        step();
        idle();
        look();
        step();
        o3 = sop(4'd6);
        drive(o3);
        look();
        check("ind_r6_rdy", dReady, 1);
        sq.push_back({o3.wb, o3.ctl});
        step();
        o2 = sop(4'd5);
        drive(o2);
        look();
        check("ind_r5_stall", dReady, 0);
        step();
        look();
        check("ind_r5_go", dReady, 1);
        sq.push_back({o2.wb, o2.ctl});
        step();
        idle();
        look();
        step();

        // Back-to-back long ops to different registers
        o1 = lop(4'd7);
        drive(o1);
        lq.push_back(4'd7);
        look();
        check("b2b_rdy0", dReady, 1);
        step();
        o2 = lop(4'd8);
        drive(o2);
        lq.push_back(4'd8);
        look();
        check("b2b_rdy1", dReady, 1);
        step();
        idle();
        look();
        step();
        look();
        check("b2b_lwb7", lwbEn, 1);
        check("b2b_lwbidx7", lwbIdx, 7);
        step();
        look();
        check("b2b_lwb8", lwbEn, 1);
        check("b2b_lwbidx8", lwbIdx, 8);
        step();
        look();
        check("b2b_done", lwbEn, 0);
        step();

        // Taken branch: flush in N, bubble in N+1, commit resumes in N+2
        o1 = sop(4'd0);
        o1.wben = 1'b0;
        o1.srwb = 1'b1;
        o1.br = 1'b1;
        drive(o1);
        look();
        step();
        o2 = sop(4'd9);
        drive(o2);
        look();
        check("br_n_flush", flush, 1);
        check("br_n_srwb", srWbEn, 1);
        check("br_n_wb", wbEn, 0);
        step();
        o3 = sop(4'd10);
        drive(o3);
        look();
        check("br_n1_evalid", eValid, 0);
        check("br_n1_wb", wbEn, 0);
        check("br_n1_flush", flush, 0);
        check("br_n1_rdy", dReady, 1);
        sq.push_back({o3.wb, o3.ctl});
        step();
        idle();
        look();
        check("br_n2_wb", wbEn, 1);
        check("br_n2_wbidx", wbIdx, 10);
        step();

        // Condition-failed branch (EQ with Z=0)
        flags = 4'b0000;
        o1 = sop(4'd0);
        o1.cond = 4'd0;
        o1.wben = 1'b0;
        o1.br = 1'b1;
        drive(o1);
        look();
        step();
        o2 = sop(4'd11);
        drive(o2);
        look();
        check("brf_flush", flush, 0);
        check("brf_rdy", dReady, 1);
        sq.push_back({o2.wb, o2.ctl});
        step();
        idle();
        look();
        check("brf_wb", wbEn, 1);
        step();

        // Exit with long ops in flight
        o1 = lop(4'd9);
        drive(o1);
        lq.push_back(4'd9);
        look();
        step();
        o2 = lop(4'd10);
        drive(o2);
        lq.push_back(4'd10);
        look();
        step();
        o3 = '0;
        o3.cond = 4'd14;
        o3.ex = 1'b1;
        drive(o3);
        look();
        step();
        idle();
        look();
        check("ex_a3_halted", halted, 0);
        check("ex_a3_lwb", lwbEn, 1);
        check("ex_a3_lwbidx", lwbIdx, 9);
        step();
        o1 = sop(4'd12);
        drive(o1);
        look();
        check("ex_a4_halted", halted, 1);
        check("ex_a4_rdy", dReady, 0);
        check("ex_a4_lwb", lwbEn, 1);
        check("ex_a4_lwbidx", lwbIdx, 10);
        step();
        look();
        check("ex_a5_evalid", eValid, 0);
        check("ex_a5_rdy", dReady, 0);
        check("ex_a5_halted", halted, 1);
        step();
        idle();
        look();
        check("ex_a6_lwb", lwbEn, 0);
        check("ex_a6_halted", halted, 1);
        step();

        // Reset clears halt; then reset mid-flight drops a long op
        reset = 1'b1;
        look();
        check("rst2_halted", halted, 0);
        check("rst2_rdy", dReady, 1);
        step();
        reset = 1'b0;
        step();
        o1 = lop(4'd11);
        drive(o1);
        look();
        check("rmf_issue_rdy", dReady, 1);
        step();
        idle();
        look();
        check("rmf_commit_evalid", eValid, 1);
        step();
        look();
        reset = 1'b1;
        #1;
        check("rmf_evalid", eValid, 0);
        check("rmf_ectl", eCtl, 0);
        check("rmf_wbidx", wbIdx, 0);
        check("rmf_lwb", lwbEn, 0);
        check("rmf_halted", halted, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            look();
            check($sformatf("rmf_after_lwb%0d", i), lwbEn, 0);
            step();
        end
        o2 = sop(4'd12);
        o2.a = 4'd11;
        o2.aen = 1'b1;
        drive(o2);
        look();
        check("rmf_busy_clear", dReady, 1);
        sq.push_back({o2.wb, o2.ctl});
        step();
        idle();
        look();
        step();
        look();

        check("sb_short_drain", sq.size(), 0);
        check("sb_long_drain", lq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
